// File: rtl/mmcm_ps_ctrl.sv
// -----------------------------------------------------------------------------
// mmcm_ps_ctrl
// Sequencer for the MMCM fine dynamic phase-shift port on CLKOUT0.
// Accepts one signed step request at a time. For each step it issues a single
// PSEN pulse and then waits for PSDONE before issuing the next one. It keeps
// the absolute phase position modulo one CLKOUT0 period. It reports successful
// completion, a missing PSDONE (timeout) and loss of MMCM lock.
//
// Ports (all synchronous to psclk except resetn):
//   psclk        controller clock, same clock as the MMCM PSCLK
//   resetn       asynchronous active-low reset
//   mmcm_locked  MMCM LOCKED
//   req_valid    request valid
//   req_ready    request can be accepted (idle and locked)
//   req_steps    signed step count; positive = increment, negative = decrement
//   psen         MMCM PSEN; a single-cycle pulse per step
//   psincdec     MMCM PSINCDEC; 1 = increment; held for the whole request
//   psdone       MMCM PSDONE
//   busy         a request is in progress
//   done         single-cycle pulse when a request completes
//   err_timeout  single-cycle pulse when PSDONE does not arrive in time
//   err_unlock   single-cycle pulse when lock is lost during a request
//   phase_pos    absolute phase position, 0..PHASE_STEPS-1
// -----------------------------------------------------------------------------
module mmcm_ps_ctrl #(
  parameter int STEP_W      = 12,
  parameter int PHASE_STEPS = 560,
  parameter int POS_W       = 10,
  parameter int TIMEOUT     = 64
) (
  input  logic              psclk,
  input  logic              resetn,
  input  logic              mmcm_locked,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [STEP_W-1:0] req_steps,
  output logic              psen,
  output logic              psincdec,
  input  logic              psdone,
  output logic              busy,
  output logic              done,
  output logic              err_timeout,
  output logic              err_unlock,
  output logic [POS_W-1:0]  phase_pos
);

  localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(PHASE_STEPS - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FINISH} state_t;

  state_t              state_q;
  logic                dir_q;
  logic [STEP_W-1:0]   remaining_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [POS_W-1:0]    pos_q;
  logic                psen_q;
  logic                done_q;
  logic                err_timeout_q;
  logic                err_unlock_q;

  logic                accept;
  logic [STEP_W-1:0]   req_mag;
  logic [STEP_W-1:0]   remaining_d;
  logic [POS_W-1:0]    pos_d;

  assign req_ready = (state_q == IDLE) && mmcm_locked;
  assign accept    = req_valid && req_ready;
  assign busy      = (state_q != IDLE);

  always_comb begin
    // Two's complement magnitude in STEP_W bits. The most negative value maps
    // to 2^(STEP_W-1), which is still representable as an unsigned count.
    req_mag     = req_steps[STEP_W-1] ? (~req_steps + STEP_W'(1)) : req_steps;
    remaining_d = remaining_q - STEP_W'(1);
    if (dir_q) begin
      pos_d = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);
    end else begin
      pos_d = (pos_q == '0) ? POS_LAST : pos_q - POS_W'(1);
    end
  end

  // The outputs are registered from the state. As a result, psen appears one
  // cycle after ISSUE. Between a PSDONE and the next PSEN there is always one
  // idle cycle.
  always_ff @(posedge psclk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      dir_q         <= 1'b0;
      remaining_q   <= '0;
      cnt_q         <= '0;
      pos_q         <= '0;
      psen_q        <= 1'b0;
      done_q        <= 1'b0;
      err_timeout_q <= 1'b0;
      err_unlock_q  <= 1'b0;
    end else begin
      psen_q        <= 1'b0;
      done_q        <= 1'b0;
      err_timeout_q <= 1'b0;
      err_unlock_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            dir_q       <= ~req_steps[STEP_W-1];
            remaining_q <= req_mag;
            state_q     <= (req_mag != '0) ? ISSUE : FINISH;
          end
        end
        ISSUE: begin
          if (!mmcm_locked) begin
            err_unlock_q <= 1'b1;
            state_q      <= IDLE;
          end else begin
            psen_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (!mmcm_locked) begin
            err_unlock_q <= 1'b1;
            state_q      <= IDLE;
          end else if (psdone) begin
            remaining_q <= remaining_d;
            pos_q       <= pos_d;
            state_q     <= (remaining_d != '0) ? ISSUE : FINISH;
          end else if (cnt_q == CNT_LAST) begin
            err_timeout_q <= 1'b1;
            state_q       <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        FINISH: begin
          // A lock loss here abandons the request without reporting done.
          done_q  <= mmcm_locked;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      // An MMCM that has lost lock will be reset, which clears its phase offset.
      if (!mmcm_locked) begin
        pos_q <= '0;
      end
    end
  end

  assign psen        = psen_q;
  assign psincdec    = dir_q;
  assign done        = done_q;
  assign err_timeout = err_timeout_q;
  assign err_unlock  = err_unlock_q;
  assign phase_pos   = pos_q;

endmodule

// File: tb/tb_mmcm_ps_ctrl.sv
module tb_mmcm_ps_ctrl;

  localparam int STEP_W      = 12;
  localparam int PHASE_STEPS = 560;
  localparam int POS_W       = 10;
  localparam int TIMEOUT     = 64;

  // Modes for the MMCM model
  localparam int M_NORMAL = 0;
  localparam int M_SILENT = 1;
  localparam int M_UNLOCK = 2;

  logic              psclk       = 1'b0;
  logic              resetn      = 1'b0;
  logic              mmcm_locked = 1'b0;
  logic              req_valid   = 1'b0;
  logic [STEP_W-1:0] req_steps   = '0;
  logic              psdone      = 1'b0;
  logic              req_ready;
  logic              psen;
  logic              psincdec;
  logic              busy;
  logic              done;
  logic              err_timeout;
  logic              err_unlock;
  logic [POS_W-1:0]  phase_pos;

  int checks    = 0;
  int errors    = 0;
  int cyc       = 0;
  int model_pos = 0;

  always #5 psclk = ~psclk;

  mmcm_ps_ctrl #(
    .STEP_W(STEP_W), .PHASE_STEPS(PHASE_STEPS), .POS_W(POS_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .psclk(psclk), .resetn(resetn), .mmcm_locked(mmcm_locked),
    .req_valid(req_valid), .req_ready(req_ready), .req_steps(req_steps),
    .psen(psen), .psincdec(psincdec), .psdone(psdone), .busy(busy),
    .done(done), .err_timeout(err_timeout), .err_unlock(err_unlock),
    .phase_pos(phase_pos)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Samples are taken 1 time unit after each rising edge.
  task automatic tick();
    @(posedge psclk);
    #1;
    cyc++;
  endtask

  function automatic int wrap_pos(input int p);
    return ((p % PHASE_STEPS) + PHASE_STEPS) % PHASE_STEPS;
  endfunction

  // A single request. The bench models the MMCM. For each observed psen, it
  // answers with psdone a random lat_min..lat_max cycles later. In silent
  // mode it never answers. In unlock mode it drops lock on the cycle after
  // psdone number unlock_after.
  task automatic run_req(input int steps, input int lat_min, input int lat_max,
                         input int mode, input int unlock_after);
    int mag, acc_cyc, budget, start_pos, exp_pos, exp_psen;
    int n_psen, n_psdone, n_done, n_tmo, n_unl;
    int last_psen, last_psdone, done_cyc, tmo_cyc;
    int bad_dir, bad_gap, overlap, multi, due;
    bit dir, pending;
    mag       = (steps < 0) ? -steps : steps;
    dir       = (steps >= 0);
    start_pos = model_pos;
    n_psen = 0; n_psdone = 0; n_done = 0; n_tmo = 0; n_unl = 0;
    last_psen = -1; last_psdone = -1; done_cyc = -1; tmo_cyc = -1;
    bad_dir = 0; bad_gap = 0; overlap = 0; multi = 0; due = 0; pending = 0;
    budget = mag * (lat_max + 4) + TIMEOUT + 40;

    check_eq("ready_before_req", int'(req_ready), 1);
    req_steps = STEP_W'(steps);
    req_valid = 1'b1;
    acc_cyc   = cyc;
    tick();
    req_valid = 1'b0;
    if (mag != 0) check_eq("busy_after_accept", int'(busy), 1);

    forever begin
      if (psen) begin
        n_psen++;
        if (psincdec !== dir) bad_dir++;
        if (pending) overlap++;
        if (last_psdone >= 0 && (cyc - last_psdone) != 2) bad_gap++;
        last_psen = cyc;
        if (mode != M_SILENT) begin
          pending = 1'b1;
          due     = cyc + int'($urandom_range(lat_max, lat_min));
        end
      end
      if (done)        begin n_done++; done_cyc = cyc; end
      if (err_timeout) begin n_tmo++;  tmo_cyc  = cyc; end
      if (err_unlock)  n_unl++;
      if (int'(done) + int'(err_timeout) + int'(err_unlock) > 1) multi++;

      psdone = 1'b0;
      if (pending && cyc == due) begin
        psdone      = 1'b1;
        pending     = 1'b0;
        n_psdone++;
        last_psdone = cyc;
      end else if (mode == M_UNLOCK && n_psdone == unlock_after && mmcm_locked) begin
        mmcm_locked = 1'b0;
      end

      if (!busy && (n_done + n_tmo + n_unl) > 0) break;
      if (cyc - acc_cyc > budget) begin
        check_eq("request_cycle_bound", 0, 1);
        break;
      end
      tick();
    end
    psdone = 1'b0;

    case (mode)
      M_SILENT: begin
        exp_psen = 1;
        exp_pos  = start_pos;
        check_eq("timeout_n_tmo", n_tmo, 1);
        check_eq("timeout_latency", tmo_cyc - last_psen, TIMEOUT);
        check_eq("timeout_n_done", n_done, 0);
      end
      M_UNLOCK: begin
        exp_psen = unlock_after;
        exp_pos  = 0;
        check_eq("unlock_n_unl", n_unl, 1);
        check_eq("unlock_n_done", n_done, 0);
      end
      default: begin
        exp_psen = mag;
        exp_pos  = wrap_pos(start_pos + steps);
        check_eq("n_done", n_done, 1);
        check_eq("n_errors", n_tmo + n_unl, 0);
        if (mag == 0) check_eq("zero_done_latency", done_cyc - acc_cyc, 2);
        else          check_eq("done_after_last_psdone", done_cyc - last_psdone, 2);
      end
    endcase
    check_eq("n_psen", n_psen, exp_psen);
    check_eq("phase_pos", int'(phase_pos), exp_pos);
    check_eq("psincdec_wrong", bad_dir, 0);
    check_eq("psen_while_pending", overlap, 0);
    check_eq("psdone_to_psen_gap", bad_gap, 0);
    check_eq("pulses_exclusive", multi, 0);
    check_eq("busy_at_end", int'(busy), 0);
    model_pos = exp_pos;
    $display("req steps=%0d mode=%0d psen=%0d done=%0d tmo=%0d unl=%0d pos=%0d",
             steps, mode, n_psen, n_done, n_tmo, n_unl, phase_pos);

    if (mode == M_UNLOCK) begin
      for (int k = 0; k < 3; k++) begin
        tick();
        check_eq("unlocked_no_psen", int'(psen), 0);
        check_eq("unlocked_ready", int'(req_ready), 0);
        check_eq("unlocked_pos", int'(phase_pos), 0);
      end
      mmcm_locked = 1'b1;
      tick();
      check_eq("relock_ready", int'(req_ready), 1);
    end else if (mode == M_SILENT) begin
      tick();
      check_eq("ready_after_timeout", int'(req_ready), 1);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int steps;
    resetn      = 1'b0;
    mmcm_locked = 1'b0;
    tick();
    tick();
    check_eq("rst_psen", int'(psen), 0);
    check_eq("rst_psincdec", int'(psincdec), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_done", int'(done), 0);
    check_eq("rst_err_timeout", int'(err_timeout), 0);
    check_eq("rst_err_unlock", int'(err_unlock), 0);
    check_eq("rst_phase_pos", int'(phase_pos), 0);
    check_eq("rst_req_ready", int'(req_ready), 0);
    resetn = 1'b1;
    tick();
    check_eq("unlocked_ready_idle", int'(req_ready), 0);
    mmcm_locked = 1'b1;
    tick();

    run_req(3, 12, 12, M_NORMAL, 0);      // 0 -> 3
    run_req(-4, 1, 6, M_NORMAL, 0);       // 3 -> 559
    run_req(2, 1, 6, M_NORMAL, 0);        // 559 -> 1
    run_req(-2, 1, 6, M_NORMAL, 0);       // 1 -> 559
    run_req(0, 1, 6, M_NORMAL, 0);

    // A PSDONE pulse that arrives while idle must not move the position.
    psdone = 1'b1;
    tick();
    psdone = 1'b0;
    tick();
    check_eq("stray_psdone_pos", int'(phase_pos), model_pos);
    check_eq("stray_psdone_busy", int'(busy), 0);

    run_req(5, 1, 1, M_SILENT, 0);
    run_req(10, 2, 8, M_UNLOCK, 4);
    run_req(-2048, 1, 3, M_NORMAL, 0);    // 0 -> 192
    check_eq("full_neg_pos", int'(phase_pos), 192);

    for (int r = 0; r < 20; r++) begin
      steps = int'($urandom_range(80, 0)) - 40;
      run_req(steps, 1, 8, M_NORMAL, 0);
    end

    // Asynchronous reset in the middle of a request
    req_steps = STEP_W'(5);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int w = 0; w < 20 && !psen; w++) tick();
    check_eq("psen_before_async_rst", int'(psen), 1);
    #2 resetn = 1'b0;
    #1;
    check_eq("async_rst_psen", int'(psen), 0);
    check_eq("async_rst_busy", int'(busy), 0);
    check_eq("async_rst_pos", int'(phase_pos), 0);
    tick();
    resetn = 1'b1;
    tick();
    check_eq("after_rst_ready", int'(req_ready), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
